// File: rtl/mem_access_unit_pkg.sv
// Shared memory-stage types: FSM states, funct3 load/store encodings,
// the captured data-memory request and legality helpers.
package corePckg;

  localparam int unsigned cPkgXlen = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } tMemState;

  localparam logic [2:0] cLb  = 3'd0;
  localparam logic [2:0] cLh  = 3'd1;
  localparam logic [2:0] cLw  = 3'd2;
  localparam logic [2:0] cLbu = 3'd4;
  localparam logic [2:0] cLhu = 3'd5;
  localparam logic [2:0] cSb  = 3'd0;
  localparam logic [2:0] cSh  = 3'd1;
  localparam logic [2:0] cSw  = 3'd2;

  typedef struct packed {
    logic                we;
    logic [cPkgXlen-1:0] addr;
    logic [cPkgXlen-1:0] wdata;
    logic [3:0]          be;
  } tDmemReq;

  function automatic logic memOpLegal(input logic isRead, input logic isWrite,
                                      input logic [2:0] funct3);
    if (isRead && isWrite) return 1'b0;
    if (isRead) return funct3 inside {cLb, cLh, cLw, cLbu, cLhu};
    return funct3 < 3'd3;
  endfunction

  // Size is encoded in funct3[1:0] for both loads and stores.
  function automatic logic memOpAligned(input logic [2:0] funct3, input logic [1:0] addrLo);
    case (funct3[1:0])
      2'd1:    return !addrLo[0];
      2'd2:    return addrLo == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Selects the addressed byte/half/word from a read word and extends it.
module mem_load_align
  import corePckg::*;
#(
  parameter int cXLEN = 32
) (
  input  logic [cXLEN-1:0] iRData,
  input  logic [1:0]       iAddrLo,
  input  logic [2:0]       iFunct3,
  output logic [cXLEN-1:0] oData
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = iRData[8*iAddrLo +: 8];
    halfSel = iRData[16*iAddrLo[1] +: 16];
    case (iFunct3)
      cLb:     oData = {{(cXLEN-8){byteSel[7]}}, byteSel};
      cLbu:    oData = {{(cXLEN-8){1'b0}}, byteSel};
      cLh:     oData = {{(cXLEN-16){halfSel[15]}}, halfSel};
      cLhu:    oData = {{(cXLEN-16){1'b0}}, halfSel};
      default: oData = iRData;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: issues one load/store at a time over a req/ack port,
// extends load data, and forwards non-memory writebacks with one cycle latency.
module mem_access_unit
  import corePckg::*;
#(
  parameter int cXLEN         = 32,
  parameter int cRegAddrWidth = 5
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iMemRead,
  input  logic                     iMemWrite,
  input  logic [cXLEN-1:0]         iMemAddr,
  input  logic [cXLEN-1:0]         iMemData,
  input  logic [2:0]               iMemOpType,
  input  logic [cRegAddrWidth-1:0] iMemRdAddr,
  input  logic                     iRegDv,
  input  logic [cRegAddrWidth-1:0] iRegAddr,
  input  logic [cXLEN-1:0]         iRegData,
  output logic                     oStall,
  output logic                     oDmemReq,
  output logic                     oDmemWe,
  output logic [cXLEN-1:0]         oDmemAddr,
  output logic [cXLEN-1:0]         oDmemWData,
  output logic [3:0]               oDmemBe,
  input  logic                     iDmemAck,
  input  logic [cXLEN-1:0]         iDmemRData,
  output logic                     oRegDv,
  output logic [cRegAddrWidth-1:0] oRegAddr,
  output logic [cXLEN-1:0]         oRegData,
  output logic                     oExcept
);

  tMemState                 state;
  tDmemReq                  req;
  logic                     isLoad;
  logic [2:0]               funct3;
  logic [1:0]               lane;
  logic [cRegAddrWidth-1:0] rd;

  logic                     memOp;
  logic                     opOk;
  logic [3:0]               nextBe;
  logic [cXLEN-1:0]         nextWData;
  logic [cXLEN-1:0]         loadVal;

  mem_load_align #(.cXLEN(cXLEN)) uLoadAlign (
    .iRData  (iDmemRData),
    .iAddrLo (lane),
    .iFunct3 (funct3),
    .oData   (loadVal)
  );

  always_comb begin
    memOp     = iMemRead | iMemWrite;
    opOk      = memOpLegal(iMemRead, iMemWrite, iMemOpType) &&
                memOpAligned(iMemOpType, iMemAddr[1:0]);
    nextBe    = 4'b1111;
    nextWData = iMemData;
    if (iMemWrite) begin
      case (iMemOpType[1:0])
        2'd0: begin
          nextBe    = 4'b0001 << iMemAddr[1:0];
          nextWData = {4{iMemData[7:0]}};
        end
        2'd1: begin
          nextBe    = 4'b0011 << {iMemAddr[1], 1'b0};
          nextWData = {2{iMemData[15:0]}};
        end
        default: nextBe = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= IDLE;
      req      <= '0;
      isLoad   <= 1'b0;
      funct3   <= '0;
      lane     <= '0;
      rd       <= '0;
      oRegDv   <= 1'b0;
      oRegAddr <= '0;
      oRegData <= '0;
      oExcept  <= 1'b0;
    end else begin
      oRegDv  <= 1'b0;
      oExcept <= 1'b0;
      case (state)
        IDLE: begin
          if (memOp) begin
            if (opOk) begin
              state  <= WAIT;
              req    <= '{we: iMemWrite, addr: {iMemAddr[cXLEN-1:2], 2'b00},
                          wdata: nextWData, be: nextBe};
              isLoad <= iMemRead;
              funct3 <= iMemOpType;
              lane   <= iMemAddr[1:0];
              rd     <= iMemRdAddr;
            end else begin
              oExcept <= 1'b1;
            end
          end else begin
            oRegDv   <= iRegDv;
            oRegAddr <= iRegAddr;
            oRegData <= iRegData;
          end
        end
        WAIT: begin
          if (iDmemAck) begin
            state <= IDLE;
            if (isLoad) begin
              oRegDv   <= (rd != '0);
              oRegAddr <= rd;
              oRegData <= loadVal;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port outputs are zeroed outside WAIT so a dropped transaction leaves nothing driven.
  assign oStall     = (state == WAIT);
  assign oDmemReq   = oStall;
  assign oDmemWe    = oStall & req.we;
  assign oDmemAddr  = oStall ? req.addr  : '0;
  assign oDmemWData = oStall ? req.wdata : '0;
  assign oDmemBe    = oStall ? req.be    : '0;

endmodule
